muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 94 +++++++++
 tb/tb_muldiv_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer for the shared shift-add multiplier and HiLo pair.
// Optional DIVU sequencing is enabled by defining the DIVU_EN macro.
module muldiv_sequencer #(
  parameter int CYCLES = 32,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       funct,
  input  logic             valid,
  output logic             stall,
  output logic             busy,
  output logic             unit_reset,
  output logic             unit_en,
  output logic             hilo_we,
  output logic [5:0]       op_out,
  output logic             div_sel,
  output logic [CNT_W-1:0] count
);

  localparam logic [5:0] MULTU     = 6'b011001;
  localparam logic [5:0] MFHI      = 6'b010000;
  localparam logic [5:0] MFLO      = 6'b010010;
  localparam logic [5:0] HILO_OPEN = 6'b111111;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, WRITE} state_t;

  state_t state, state_nxt;
  logic   seq_op;

`ifdef DIVU_EN
  localparam logic [5:0] DIVU = 6'b011011;
  assign seq_op = (funct == MULTU) || (funct == DIVU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_sel <= 1'b0;
    else if (state == IDLE && valid && seq_op)
      div_sel <= (funct == DIVU);
    else if (state == WRITE)
      div_sel <= 1'b0;
  end
`else
  assign seq_op  = (funct == MULTU);
  assign div_sel = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && count != LAST)
        count <= count + 1'b1;
      else
        count <= '0;
    end
  end

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    unit_reset = 1'b0;
    unit_en    = 1'b0;
    hilo_we    = 1'b0;
    op_out     = valid ? funct : 6'b000000;
    case (state)
      IDLE: if (valid && seq_op) state_nxt = CLEAR;
      CLEAR: begin
        unit_reset = 1'b1;
        stall      = valid && (seq_op || funct == MFHI || funct == MFLO);
        state_nxt  = RUN;
      end
      RUN: begin
        unit_en = 1'b1;
        stall   = valid && (seq_op || funct == MFHI || funct == MFLO);
        if (count == LAST) state_nxt = WRITE;
      end
      WRITE: begin
        // op_out is taken by the HiLo write, so every valid op must wait
        hilo_we   = 1'b1;
        op_out    = HILO_OPEN;
        stall     = valid;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed scenarios then random
// traffic, compared each cycle against a timeline model of the operation.
module tb_muldiv_sequencer;
  localparam int C = 32;
  localparam logic [5:0] ADD = 6'b100000, MULTU = 6'b011001, MFHI = 6'b010000,
                         MFLO = 6'b010010, DIVU = 6'b011011, SRL = 6'b000010;
`ifdef DIVU_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, valid = 1'b0;
  logic [5:0] funct = '0;
  logic       stall, busy, unit_reset, unit_en, hilo_we, div_sel;
  logic [5:0] op_out;
  logic [5:0] count;

  int checks = 0, errors = 0;
  int k = 0;        // cycles since the accepting edge; 0 = no operation in flight
  bit ds = 1'b0;    // operation in flight is a divide

  muldiv_sequencer #(.CYCLES(C), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .funct(funct), .valid(valid), .stall(stall),
    .busy(busy), .unit_reset(unit_reset), .unit_en(unit_en), .hilo_we(hilo_we),
    .op_out(op_out), .div_sel(div_sel), .count(count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, req, k);
    end
  endtask

  function automatic bit is_seq(input logic [5:0] f);
    return (f == MULTU) || (DIV_ON && f == DIVU);
  endfunction

  // One clock cycle: drive at negedge, check before posedge, advance model.
  task automatic cyc(input logic v, input logic [5:0] f);
    bit run, wr, exp_stall;
    valid = v; funct = f;
    #1;
    run = (k >= 2 && k <= C + 1);
    wr  = (k == C + 2);
    if (k == 0)  exp_stall = 1'b0;
    else if (wr) exp_stall = v;
    else         exp_stall = v && (is_seq(f) || f == MFHI || f == MFLO);
    check("busy",       busy,       k != 0);
    check("unit_reset", unit_reset, k == 1);
    check("unit_en",    unit_en,    run);
    check("hilo_we",    hilo_we,    wr);
    check("count",      count,      run ? k - 2 : 0);
    check("op_out",     op_out,     wr ? 6'h3f : (v ? f : 6'h00));
    check("stall",      stall,      exp_stall);
    check("div_sel",    div_sel,    DIV_ON && k != 0 && ds);
    @(posedge clk);
    if (k == 0) begin
      if (v && is_seq(f)) begin k = 1; ds = (f == DIVU); end
    end else if (wr) begin
      k = 0; ds = 1'b0;
    end else k++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'h00);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    valid = 1'b0; funct = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_en",   {unit_reset, unit_en, hilo_we, stall, div_sel}, 0);
    check("rst_cnt",  count, 0);
    check("rst_op",   op_out, 0);
    k = 0; ds = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [5:0] codes [12] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
                            6'b000010, 6'b011001, 6'b010000, 6'b010010, 6'b011011,
                            6'b011001, 6'b000000};

  initial begin
    repeat (2) @(negedge clk);
    check("init_busy", busy, 0);
    check("init_out",  {unit_reset, unit_en, hilo_we, stall, div_sel}, 0);
    check("init_op",   op_out, 0);
    reset = 1'b0;
    idle(2);

    // MULTU, independent ADD at cycle 10, MFLO held from cycle 12 until idle
    cyc(1'b1, MULTU);
    idle(9);
    cyc(1'b1, ADD);
    cyc(1'b0, 6'h00);
    repeat (24) cyc(1'b1, MFLO);
    idle(2);

    // back-to-back MULTU: the second is held until accepted
    repeat (36) cyc(1'b1, MULTU);
    idle(36);

    // reset during RUN at count=15, then a normal MULTU
    cyc(1'b1, MULTU);
    repeat (16) cyc(1'b1, SRL);
    check("pre_rst_cnt", count, 15);
    pulse_reset();
    idle(40);
    cyc(1'b1, MULTU);
    idle(36);

    // DIVU: sequenced only when the divider is built in
    cyc(1'b1, DIVU);
    idle(36);
    cyc(1'b1, MFHI);

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 11)];
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else cyc(1'($urandom_range(0, 1)), f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
